// File: rtl/kdtree_pkg.sv
// rtl/kdtree_pkg.sv - shared KD-tree node types, sizes and 32-bit node word packing
//
// Purpose: one place for the internal-node record layout so the node table,
// its lookup ports and the Wishbone/stream word format stay in agreement.
// Packed word: [IDX_W-1:0] idx, [2*DATA_WIDTH-1:DATA_WIDTH] median, rest zero.
package kdtree_pkg;

  localparam int DATA_WIDTH = 11;
  localparam int IDX_W      = 3;
  localparam int NUM_LEAVES = 64;
  localparam int NUM_NODES  = NUM_LEAVES - 1;
  localparam int ADDR_W     = $clog2(NUM_NODES);

  // Base of the node table in the wbsCtrl address map; wbsCtrl strips it
  // before the index reaches this block.
  localparam logic [31:0] WBS_NODE_ADDR = 32'h3000_1000;

  // All-ones split index marks a node that has not been given a split yet.
  localparam logic [IDX_W-1:0] NODE_IDX_DEFAULT = '1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] median;
    logic [IDX_W-1:0]      idx;
  } node_t;

  localparam node_t NODE_DEFAULT = '{median: '0, idx: NODE_IDX_DEFAULT};

  typedef enum logic {
    LD_RUN  = 1'b0,
    LD_DONE = 1'b1
  } load_state_e;

  function automatic logic [31:0] pack_node(node_t n);
    logic [31:0] w;
    w = '0;
    w[IDX_W-1:0]                 = n.idx;
    w[2*DATA_WIDTH-1:DATA_WIDTH] = n.median;
    return w;
  endfunction

  // Padding bits of the word carry no meaning and are dropped.
  function automatic node_t unpack_node(logic [31:0] w);
    node_t n;
    logic  unused_pad;
    unused_pad = ^{w[31:2*DATA_WIDTH], w[DATA_WIDTH-1:IDX_W]};
    n.idx      = w[IDX_W-1:0];
    n.median   = w[2*DATA_WIDTH-1:DATA_WIDTH];
    return n;
  endfunction

endpackage

// File: rtl/node_table_ctrl_if.sv
// rtl/node_table_ctrl_if.sv - bus bundle for the node table: Wishbone node port, load stream, two lookups
//
// Purpose: groups every non-clock/reset signal of node_table_ctrl.
// Ports (as seen by the table, modport slave):
//   in : wbs_mode, wbs_node_mem_{csb,web,addr,wdata}, load_{start,valid,data},
//        lk0/lk1_{valid,addr}
//   out: wbs_node_mem_rdata, load_ready, load_done, lk0/lk1_{rvalid,median,idx}
interface node_table_ctrl_if;

  logic                             wbs_mode;
  logic                             wbs_node_mem_csb;
  logic                             wbs_node_mem_web;
  logic [31:0]                      wbs_node_mem_addr;
  logic [31:0]                      wbs_node_mem_wdata;
  logic [31:0]                      wbs_node_mem_rdata;

  logic                             load_start;
  logic                             load_valid;
  logic [31:0]                      load_data;
  logic                             load_ready;
  logic                             load_done;

  logic                             lk0_valid;
  logic [kdtree_pkg::ADDR_W-1:0]    lk0_addr;
  logic                             lk0_rvalid;
  logic [kdtree_pkg::DATA_WIDTH-1:0] lk0_median;
  logic [kdtree_pkg::IDX_W-1:0]     lk0_idx;

  logic                             lk1_valid;
  logic [kdtree_pkg::ADDR_W-1:0]    lk1_addr;
  logic                             lk1_rvalid;
  logic [kdtree_pkg::DATA_WIDTH-1:0] lk1_median;
  logic [kdtree_pkg::IDX_W-1:0]     lk1_idx;

  modport master (
    output wbs_mode, wbs_node_mem_csb, wbs_node_mem_web, wbs_node_mem_addr,
           wbs_node_mem_wdata, load_start, load_valid, load_data,
           lk0_valid, lk0_addr, lk1_valid, lk1_addr,
    input  wbs_node_mem_rdata, load_ready, load_done,
           lk0_rvalid, lk0_median, lk0_idx, lk1_rvalid, lk1_median, lk1_idx
  );

  modport slave (
    input  wbs_mode, wbs_node_mem_csb, wbs_node_mem_web, wbs_node_mem_addr,
           wbs_node_mem_wdata, load_start, load_valid, load_data,
           lk0_valid, lk0_addr, lk1_valid, lk1_addr,
    output wbs_node_mem_rdata, load_ready, load_done,
           lk0_rvalid, lk0_median, lk0_idx, lk1_rvalid, lk1_median, lk1_idx
  );

endinterface

// File: rtl/node_table_lookup.sv
// rtl/node_table_lookup.sv - one registered traversal lookup port into the node table
//
// Purpose: reads one node per accepted request with one cycle of latency.
// Ports:
//   wb_clk_i, wb_rst_i : clock, synchronous active-high reset
//   node_table         : current table contents
//   req                : request accepted this cycle (already gated)
//   addr               : node index; out-of-range gives the default node
//   rvalid             : result valid, one cycle after req
//   median, idx        : node fields, held when no request is accepted
module node_table_lookup
  import kdtree_pkg::*;
(
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  node_t                 node_table [NUM_NODES],
  input  logic                  req,
  input  logic [ADDR_W-1:0]     addr,
  output logic                  rvalid,
  output logic [DATA_WIDTH-1:0] median,
  output logic [IDX_W-1:0]      idx
);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      rvalid <= 1'b0;
      median <= '0;
      idx    <= '0;
    end else begin
      rvalid <= req;
      if (req) begin
        if (addr < ADDR_W'(NUM_NODES)) begin
          median <= node_table[addr].median;
          idx    <= node_table[addr].idx;
        end else begin
          median <= NODE_DEFAULT.median;
          idx    <= NODE_DEFAULT.idx;
        end
      end
    end
  end

endmodule

// File: rtl/node_table_ctrl.sv
// rtl/node_table_ctrl.sv - KD-tree internal-node table: Wishbone debug port, streaming loader, dual lookup
//
// Purpose: holds NUM_NODES {median, idx} entries. In Wishbone mode the
// table is read/written through wbsCtrl's node-memory port; in normal mode
// it is filled by a stream and then serves two independent lookups.
// Ports:
//   wb_clk_i, wb_rst_i : clock, synchronous active-high reset
//   bus (slave)        : Wishbone node port, load stream, lk0/lk1 lookups
module node_table_ctrl
  import kdtree_pkg::*;
(
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  node_table_ctrl_if.slave  bus
);

  node_t             node_mem [NUM_NODES];
  load_state_e       ld_state;
  logic [ADDR_W-1:0] ld_ptr;
  logic              load_done_q;
  logic [31:0]       rdata_q;

  logic              wb_hit;
  logic [ADDR_W-1:0] wb_idx;
  logic              lk0_req;
  logic              lk1_req;

  assign wb_hit = bus.wbs_node_mem_addr < 32'(NUM_NODES);
  assign wb_idx = bus.wbs_node_mem_addr[ADDR_W-1:0];

  // A lookup is only meaningful once the whole tree is in place.
  assign lk0_req = bus.lk0_valid & load_done_q & ~bus.wbs_mode;
  assign lk1_req = bus.lk1_valid & load_done_q & ~bus.wbs_mode;

  assign bus.load_ready         = ~load_done_q & ~bus.load_start & ~bus.wbs_mode;
  assign bus.load_done          = load_done_q;
  assign bus.wbs_node_mem_rdata = rdata_q;

  // Storage, Wishbone port and load FSM share one process: wbs_mode selects
  // exactly one writer, so the table never has two write sources per cycle.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < NUM_NODES; i++) begin
        node_mem[i] <= NODE_DEFAULT;
      end
      ld_state    <= LD_RUN;
      ld_ptr      <= '0;
      load_done_q <= 1'b0;
      rdata_q     <= '0;
    end else if (bus.wbs_mode) begin
      // Load state is left untouched here, so an interrupted load resumes.
      if (!bus.wbs_node_mem_csb) begin
        if (!bus.wbs_node_mem_web) begin
          if (wb_hit) begin
            node_mem[wb_idx] <= unpack_node(bus.wbs_node_mem_wdata);
          end
        end else begin
          rdata_q <= wb_hit ? pack_node(node_mem[wb_idx]) : 32'h0;
        end
      end
    end else if (bus.load_start) begin
      ld_state    <= LD_RUN;
      ld_ptr      <= '0;
      load_done_q <= 1'b0;
    end else begin
      case (ld_state)
        LD_RUN: begin
          if (bus.load_valid) begin
            node_mem[ld_ptr] <= unpack_node(bus.load_data);
            // The pointer parks on the last entry rather than wrapping.
            if (ld_ptr == ADDR_W'(NUM_NODES - 1)) begin
              ld_state    <= LD_DONE;
              load_done_q <= 1'b1;
            end else begin
              ld_ptr <= ld_ptr + 1'b1;
            end
          end
        end
        LD_DONE: begin
          load_done_q <= 1'b1;
        end
        default: begin
          ld_state <= LD_RUN;
        end
      endcase
    end
  end

  node_table_lookup u_lk0 (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_i   (wb_rst_i),
    .node_table (node_mem),
    .req        (lk0_req),
    .addr       (bus.lk0_addr),
    .rvalid     (bus.lk0_rvalid),
    .median     (bus.lk0_median),
    .idx        (bus.lk0_idx)
  );

  node_table_lookup u_lk1 (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_i   (wb_rst_i),
    .node_table (node_mem),
    .req        (lk1_req),
    .addr       (bus.lk1_addr),
    .rvalid     (bus.lk1_rvalid),
    .median     (bus.lk1_median),
    .idx        (bus.lk1_idx)
  );

endmodule

// File: tb/tb_node_table_ctrl.sv
// tb/tb_node_table_ctrl.sv - directed self-checking bench for node_table_ctrl
module tb_node_table_ctrl;

  logic wb_clk_i = 1'b0;
  logic wb_rst_i = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  node_table_ctrl_if bus ();

  node_table_ctrl dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .bus      (bus)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  function automatic logic [31:0] word(int med, int ix);
    return (32'(med) << 11) | 32'(ix);
  endfunction

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
    bus.wbs_node_mem_csb   = 1'b0;
    bus.wbs_node_mem_web   = 1'b0;
    bus.wbs_node_mem_addr  = a;
    bus.wbs_node_mem_wdata = d;
    tick();
    bus.wbs_node_mem_csb   = 1'b1;
    bus.wbs_node_mem_web   = 1'b1;
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
    bus.wbs_node_mem_csb  = 1'b0;
    bus.wbs_node_mem_web  = 1'b1;
    bus.wbs_node_mem_addr = a;
    tick();
    d = bus.wbs_node_mem_rdata;
    bus.wbs_node_mem_csb  = 1'b1;
  endtask

  // Streams beats first..first+count-1 with median=base+n, idx=n%8.
  task automatic stream(input int first, input int count, input int base, input bit gaps);
    int n   = first;
    int cyc = 0;
    while (n < first + count && cyc < 400) begin
      bus.load_valid = !(gaps && (cyc % 3 == 2));
      bus.load_data  = word(base + n, n % 8) | 32'hFFC0_07F8;
      #1;
      if (bus.load_valid && bus.load_ready) n++;
      tick();
      cyc++;
    end
    bus.load_valid = 1'b0;
    checks++;
    if (n !== first + count) begin
      failures++;
      $display("FAIL stream_budget beats=%0d required=%0d", n - first, count);
    end
  endtask

  task automatic load_restart();
    bus.wbs_mode   = 1'b0;
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    repeat (2) tick();
    wb_rst_i = 1'b0;
    #1;
    checks++; if (bus.load_done !== 1'b0) begin failures++; $display("FAIL rst_load_done got=%0b exp=0", bus.load_done); end
    checks++; if (bus.wbs_node_mem_rdata !== 32'h0) begin failures++; $display("FAIL rst_rdata got=%h exp=0", bus.wbs_node_mem_rdata); end
    checks++; if (bus.lk0_rvalid !== 1'b0 || bus.lk1_rvalid !== 1'b0) begin failures++; $display("FAIL rst_rvalid got=%0b%0b exp=00", bus.lk0_rvalid, bus.lk1_rvalid); end
    checks++; if (bus.lk0_median !== '0 || bus.lk0_idx !== '0) begin failures++; $display("FAIL rst_lk0_data got=%h/%h exp=0/0", bus.lk0_median, bus.lk0_idx); end
    checks++; if (bus.load_ready !== 1'b0) begin failures++; $display("FAIL rst_ready_wbmode got=%0b exp=0", bus.load_ready); end
    wb_read(32'd1, d);
    checks++; if (d !== 32'h0000_0007) begin failures++; $display("FAIL rst_read1 got=%h exp=00000007", d); end
  endtask

  task automatic test_wb_rw();
    logic [31:0] d;
    logic [31:0] e;
    wb_write(32'd1, 32'h0001_B801);
    wb_write(32'd2, 32'hFFFF_FFFF);
    wb_write(32'd63, 32'h0001_B801);
    wb_write(32'd200, 32'h0001_B801);
    wb_read(32'd63, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL wb_read63 got=%h exp=0", d); end
    for (int k = 0; k < 63; k++) begin
      wb_read(32'(k), d);
      e = (k == 1) ? 32'h0001_B801 : (k == 2) ? 32'h003F_F807 : 32'h0000_0007;
      checks++; if (d !== e) begin failures++; $display("FAIL wb_entry%0d got=%h exp=%h", k, d, e); end
    end
    wb_read(32'd1, d);
    // Port ignored outside Wishbone mode: no write, rdata holds.
    bus.wbs_mode = 1'b0;
    wb_write(32'd4, 32'hFFFF_FFFF);
    wb_read(32'd4, d);
    checks++; if (d !== 32'h0001_B801) begin failures++; $display("FAIL wb_mode0_hold got=%h exp=0001b801", d); end
    bus.wbs_mode = 1'b1;
    wb_read(32'd4, d);
    checks++; if (d !== 32'h0000_0007) begin failures++; $display("FAIL wb_mode0_nowrite got=%h exp=00000007", d); end
  endtask

  task automatic test_load_lookup();
    logic [31:0] d;
    bus.wbs_mode   = 1'b0;
    bus.load_start = 1'b1;
    #1;
    checks++; if (bus.load_ready !== 1'b0) begin failures++; $display("FAIL ready_during_start got=%0b exp=0", bus.load_ready); end
    tick();
    bus.load_start = 1'b0;
    bus.lk0_valid = 1'b1; bus.lk0_addr = 6'd3;
    tick();
    bus.lk0_valid = 1'b0;
    checks++; if (bus.lk0_rvalid !== 1'b0) begin failures++; $display("FAIL lk_before_done got=%0b exp=0", bus.lk0_rvalid); end
    stream(0, 63, 0, 1'b1);
    #1;
    checks++; if (bus.load_done !== 1'b1) begin failures++; $display("FAIL load_done got=%0b exp=1", bus.load_done); end
    checks++; if (bus.load_ready !== 1'b0) begin failures++; $display("FAIL ready_after_done got=%0b exp=0", bus.load_ready); end
    bus.lk0_valid = 1'b1; bus.lk0_addr = 6'd10;
    tick();
    checks++; if ({bus.lk0_rvalid, bus.lk0_median, bus.lk0_idx} !== {1'b1, 11'd10, 3'd2}) begin failures++; $display("FAIL lk0_addr10 got=%0b/%0d/%0d exp=1/10/2", bus.lk0_rvalid, bus.lk0_median, bus.lk0_idx); end
    bus.lk0_addr = 6'd5; bus.lk1_valid = 1'b1; bus.lk1_addr = 6'd5;
    tick();
    checks++; if ({bus.lk0_rvalid, bus.lk0_median, bus.lk0_idx} !== {1'b1, 11'd5, 3'd5}) begin failures++; $display("FAIL lk0_same5 got=%0b/%0d/%0d exp=1/5/5", bus.lk0_rvalid, bus.lk0_median, bus.lk0_idx); end
    checks++; if ({bus.lk1_rvalid, bus.lk1_median, bus.lk1_idx} !== {1'b1, 11'd5, 3'd5}) begin failures++; $display("FAIL lk1_same5 got=%0b/%0d/%0d exp=1/5/5", bus.lk1_rvalid, bus.lk1_median, bus.lk1_idx); end
    bus.lk0_valid = 1'b0; bus.lk1_addr = 6'd63;
    tick();
    checks++; if ({bus.lk0_rvalid, bus.lk0_median, bus.lk0_idx} !== {1'b0, 11'd5, 3'd5}) begin failures++; $display("FAIL lk0_hold got=%0b/%0d/%0d exp=0/5/5", bus.lk0_rvalid, bus.lk0_median, bus.lk0_idx); end
    checks++; if ({bus.lk1_rvalid, bus.lk1_median, bus.lk1_idx} !== {1'b1, 11'd0, 3'd7}) begin failures++; $display("FAIL lk1_oob got=%0b/%0d/%0d exp=1/0/7", bus.lk1_rvalid, bus.lk1_median, bus.lk1_idx); end
    bus.wbs_mode = 1'b1;
    bus.lk1_addr = 6'd9;
    tick();
    bus.lk1_valid = 1'b0;
    checks++; if (bus.lk1_rvalid !== 1'b0) begin failures++; $display("FAIL lk1_in_wbmode got=%0b exp=0", bus.lk1_rvalid); end
    wb_read(32'd62, d);
    checks++; if (d !== 32'h0001_F006) begin failures++; $display("FAIL wb_after_load62 got=%h exp=0001f006", d); end
  endtask

  task automatic test_mode_pause();
    logic [31:0] d;
    load_restart();
    stream(0, 30, 100, 1'b0);
    bus.wbs_mode   = 1'b1;
    bus.load_valid = 1'b1;
    bus.load_data  = word(999, 3);
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if (bus.load_ready !== 1'b0) begin failures++; $display("FAIL pause_ready c=%0d got=%0b exp=0", c, bus.load_ready); end
      tick();
    end
    bus.load_valid = 1'b0;
    bus.wbs_mode   = 1'b0;
    stream(30, 33, 100, 1'b1);
    #1;
    checks++; if (bus.load_done !== 1'b1) begin failures++; $display("FAIL pause_done got=%0b exp=1", bus.load_done); end
    bus.wbs_mode = 1'b1;
    for (int k = 28; k < 63; k += 17) begin
      wb_read(32'(k), d);
      checks++; if (d !== word(100 + k, k % 8)) begin failures++; $display("FAIL pause_entry%0d got=%h exp=%h", k, d, word(100 + k, k % 8)); end
    end
    // Start and valid in the same cycle: start wins, beat discarded.
    bus.wbs_mode   = 1'b0;
    bus.load_start = 1'b1;
    bus.load_valid = 1'b1;
    bus.load_data  = word(500, 1);
    tick();
    bus.load_start = 1'b0;
    checks++; if (bus.load_done !== 1'b0) begin failures++; $display("FAIL start_clears_done got=%0b exp=0", bus.load_done); end
    bus.load_data = word(600, 2);
    tick();
    bus.load_valid = 1'b0;
    bus.wbs_mode   = 1'b1;
    wb_read(32'd0, d);
    checks++; if (d !== word(600, 2)) begin failures++; $display("FAIL start_beat_entry0 got=%h exp=%h", d, word(600, 2)); end
    wb_read(32'd1, d);
    checks++; if (d !== word(101, 1)) begin failures++; $display("FAIL start_beat_entry1 got=%h exp=%h", d, word(101, 1)); end
  endtask

  task automatic test_reset_midload();
    logic [31:0] d;
    load_restart();
    stream(0, 63, 0, 1'b0);
    bus.lk0_valid = 1'b1; bus.lk0_addr = 6'd3;
    tick();
    bus.lk0_valid = 1'b0;
    checks++; if ({bus.lk0_rvalid, bus.lk0_median, bus.lk0_idx} !== {1'b1, 11'd3, 3'd3}) begin failures++; $display("FAIL pre_rst_lk0 got=%0b/%0d/%0d exp=1/3/3", bus.lk0_rvalid, bus.lk0_median, bus.lk0_idx); end
    bus.wbs_mode = 1'b1;
    wb_read(32'd5, d);
    checks++; if (d !== word(5, 5)) begin failures++; $display("FAIL pre_rst_read5 got=%h exp=%h", d, word(5, 5)); end
    load_restart();
    stream(0, 20, 200, 1'b0);
    wb_rst_i       = 1'b1;
    bus.lk0_valid  = 1'b1;
    bus.load_valid = 1'b1;
    tick();
    wb_rst_i       = 1'b0;
    bus.lk0_valid  = 1'b0;
    bus.load_valid = 1'b0;
    checks++; if (bus.load_done !== 1'b0) begin failures++; $display("FAIL midrst_done got=%0b exp=0", bus.load_done); end
    checks++; if ({bus.lk0_rvalid, bus.lk0_median, bus.lk0_idx} !== 15'd0) begin failures++; $display("FAIL midrst_lk0 got=%0b/%0d/%0d exp=0/0/0", bus.lk0_rvalid, bus.lk0_median, bus.lk0_idx); end
    checks++; if (bus.wbs_node_mem_rdata !== 32'h0) begin failures++; $display("FAIL midrst_rdata got=%h exp=0", bus.wbs_node_mem_rdata); end
    bus.wbs_mode = 1'b1;
    wb_read(32'd3, d);
    checks++; if (d !== 32'h0000_0007) begin failures++; $display("FAIL midrst_read3 got=%h exp=00000007", d); end
  endtask

  initial begin
    bus.wbs_mode           = 1'b1;
    bus.wbs_node_mem_csb   = 1'b1;
    bus.wbs_node_mem_web   = 1'b1;
    bus.wbs_node_mem_addr  = '0;
    bus.wbs_node_mem_wdata = '0;
    bus.load_start         = 1'b0;
    bus.load_valid         = 1'b0;
    bus.load_data          = '0;
    bus.lk0_valid          = 1'b0;
    bus.lk0_addr           = '0;
    bus.lk1_valid          = 1'b0;
    bus.lk1_addr           = '0;
    test_reset();
    test_wb_rw();
    test_load_lookup();
    test_mode_pause();
    test_reset_midload();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

endmodule
